// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared operation codes and sequencer state encoding for the
//            multi-cycle shifter controller.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Shift operation encodings
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // Stage amount select: 00 = 1, 01 = 2, 10 = 4, 11 = 8
    localparam logic [1:0] AMT_1 = 2'b00;
    localparam logic [1:0] AMT_2 = 2'b01;
    localparam logic [1:0] AMT_4 = 2'b10;
    localparam logic [1:0] AMT_8 = 2'b11;

    // Sequencer states: one pass per power-of-two amount, largest first
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ST8  = 3'd1,
        ST4  = 3'd2,
        ST2  = 3'd3,
        ST1  = 3'd4
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage
// Brief    : Single combinational shift stage; shifts/rotates a 16-bit word
//            by 1, 2, 4 or 8 positions according to op.
// Revision : 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_pkg::*;
(
    input  logic [15:0] in,
    input  logic [1:0]  op,
    input  logic [1:0]  amt,
    output logic [15:0] out
);

    logic [4:0]  k;
    logic [31:0] rot;

    // Decode the amount and apply the selected operation
    always_comb begin
        k   = 5'd1 << amt;
        // Shifting the doubled word left leaves the rotated result in the
        // upper half: bits leaving the MSB reappear at the LSB end.
        rot = {in, in} << k;
        out = in;
        case (op)
            OP_ROL:  out = rot[31:16];
            OP_SLL:  out = in << k;
            OP_SRA:  out = $signed(in) >>> k;
            OP_SRL:  out = in >> k;
            default: out = in;
        endcase
    end

endmodule : shift_stage
`default_nettype wire

// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl
// Brief    : Multi-cycle shift sequencer. Captures one request, then makes
//            four passes (8, 4, 2, 1) through one shared shift stage, each
//            pass applied only when the matching amount bit is set.
// Revision : 1.0 - initial release
// ============================================================================
module shift_ctrl
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [1:0]  op,
    input  logic [3:0]  cnt,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    state_t      state_q, state_d;
    logic [15:0] acc_q,   acc_d;
    logic [1:0]  op_q,    op_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] out_q,   out_d;
    logic        done_q,  done_d;

    logic [1:0]  stage_amt;
    logic [15:0] stage_out;
    logic [15:0] pass_val;

    // Stage amount follows the current pass; the matching cnt bit gates it
    always_comb begin
        stage_amt = AMT_1;
        case (state_q)
            ST8:     stage_amt = AMT_8;
            ST4:     stage_amt = AMT_4;
            ST2:     stage_amt = AMT_2;
            ST1:     stage_amt = AMT_1;
            default: stage_amt = AMT_1;
        endcase
        // AMT_n encodes log2(n), which is also the cnt bit index for that pass
        pass_val = cnt_q[stage_amt] ? stage_out : acc_q;
    end

    shift_stage u_stage (
        .in  (acc_q),
        .op  (op_q),
        .amt (stage_amt),
        .out (stage_out)
    );

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = in;
                    op_d    = op;
                    cnt_d   = cnt;
                    state_d = ST8;
                end
            end
            ST8: begin
                acc_d   = pass_val;
                state_d = ST4;
            end
            ST4: begin
                acc_d   = pass_val;
                state_d = ST2;
            end
            ST2: begin
                acc_d   = pass_val;
                state_d = ST1;
            end
            ST1: begin
                acc_d   = pass_val;
                out_d   = pass_val;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            op_q    <= 2'b00;
            cnt_q   <= 4'h0;
            out_q   <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // busy is a decode of the state flop only, so no input reaches an output
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign out  = out_q;

endmodule : shift_ctrl
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_ctrl
// Brief    : Self-checking bench for shift_ctrl: directed cases, reset in
//            flight, back-to-back requests and a randomized op x cnt sweep
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_s;
    logic [1:0]  op_s;
    logic [3:0]  cnt_s;
    logic        busy;
    logic        done;
    logic [15:0] out_s;

    int          n_vec;
    int          n_err;
    logic [15:0] prev_out;

    shift_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in_s),
        .op    (op_s),
        .cnt   (cnt_s),
        .busy  (busy),
        .done  (done),
        .out   (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: the full shift computed in one step from the operation rules
    function automatic logic [15:0] ref_model(input logic [15:0] a,
                                              input logic [1:0]  o,
                                              input logic [3:0]  c);
        logic [31:0] d;
        logic [15:0] r;
        d = 32'h0;
        r = a;
        case (o)
            2'b00: begin d = {a, a} << c; r = d[31:16]; end
            2'b01: r = a << c;
            2'b10: r = $signed(a) >>> c;
            2'b11: r = a >> c;
            default: r = a;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: accept, four busy cycles, then the done cycle.
    // With hold set, start stays high with the next request during busy.
    task automatic run_req(input logic [15:0] a, input logic [1:0] o,
                           input logic [3:0] c, input logic [15:0] exp,
                           input bit hold, input logic [15:0] na,
                           input logic [1:0] no, input logic [3:0] nc);
        @(negedge clk);
        start = 1'b1; in_s = a; op_s = o; cnt_s = c;
        @(posedge clk); #1;
        check("accept_busy", {15'b0, busy}, 16'h1);
        check("accept_done", {15'b0, done}, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (hold) begin
                start = 1'b1; in_s = na; op_s = no; cnt_s = nc;
            end else begin
                start = 1'($urandom_range(0, 1));
                in_s  = 16'($urandom);
                op_s  = 2'($urandom);
                cnt_s = 4'($urandom);
            end
            @(posedge clk); #1;
            if (i < 3) begin
                check("inflight_busy", {15'b0, busy}, 16'h1);
                check("inflight_done", {15'b0, done}, 16'h0);
                check("inflight_out",  out_s, prev_out);
            end else begin
                check("done_busy", {15'b0, busy}, 16'h0);
                check("done_pulse", {15'b0, done}, 16'h1);
                check("result", out_s, exp);
                prev_out = exp;
            end
        end
        if (!hold) start = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        prev_out = 16'h0000;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_s     = 16'h0;
        op_s     = 2'b00;
        cnt_s    = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {15'b0, busy}, 16'h0);
        check("rst_done", {15'b0, done}, 16'h0);
        check("rst_out",  out_s, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_req(16'h8001, 2'b00, 4'd4,  16'h0018, 1'b0, 16'h0, 2'b0, 4'h0);
        run_req(16'h00FF, 2'b01, 4'd8,  16'hFF00, 1'b0, 16'h0, 2'b0, 4'h0);
        run_req(16'h8000, 2'b10, 4'd15, 16'hFFFF, 1'b0, 16'h0, 2'b0, 4'h0);
        run_req(16'h8000, 2'b11, 4'd15, 16'h0001, 1'b0, 16'h0, 2'b0, 4'h0);
        run_req(16'h1234, 2'b00, 4'd0,  16'h1234, 1'b0, 16'h0, 2'b0, 4'h0);

        // Start held during busy: B ignored, then accepted in A's done cycle
        run_req(16'h0001, 2'b01, 4'd1, 16'h0002, 1'b1, 16'hFFFF, 2'b11, 4'd4);
        run_req(16'hFFFF, 2'b11, 4'd4, 16'h0FFF, 1'b0, 16'h0, 2'b0, 4'h0);

        // Reset asserted during the by-2 pass
        @(negedge clk);
        start = 1'b1; in_s = 16'h1234; op_s = 2'b00; cnt_s = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", {15'b0, busy}, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {15'b0, busy}, 16'h0);
        check("async_rst_done", {15'b0, done}, 16'h0);
        check("async_rst_out",  out_s, 16'h0000);
        prev_out = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_done", {15'b0, done}, 16'h0);
            check("post_rst_busy", {15'b0, busy}, 16'h0);
        end
        run_req(16'hA5C3, 2'b00, 4'd7, ref_model(16'hA5C3, 2'b00, 4'd7),
                1'b0, 16'h0, 2'b0, 4'h0);

        // Randomized sweep over every op and amount
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 16; c++) begin
                logic [15:0] a;
                a = 16'($urandom);
                run_req(a, 2'(o), 4'(c), ref_model(a, 2'(o), 4'(c)),
                        1'b0, 16'h0, 2'b0, 4'h0);
            end
        end

        // Done must have dropped after the final completion
        @(posedge clk); #1;
        check("final_done_low", {15'b0, done}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_ctrl
`default_nettype wire

// File: doc/shift_ctrl.md
# shift_ctrl

Multi-cycle sequencer for the 16-bit shifter datapath. It accepts one shift request, with an operand, a 2-bit operation and a 4-bit amount, and holds it in a working register. It then makes four fixed passes through a single shared shift stage, by 8, then 4, then 2, then 1. Each pass is applied only when the matching amount bit is set. The block sits between the execute-stage issue logic and the shifter, trading latency for a single stage instance instead of a four-stage barrel.

## Interface
- No parameters; width fixed at 16 bits, amount fixed at 4 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only while busy is low.
- in  input  16  operand, captured on the accepting edge.
- op  input  2  operation, captured with in: 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
- cnt  input  4  shift amount 0–15, captured with in.
- busy  output  1  high while a request is in flight.
- done  output  1  single-cycle pulse; result valid on out.
- out  output  16  last completed result; held until the next completion.

## Operation
- States: IDLE, ST8, ST4, ST2, ST1. busy = (state != IDLE).
- IDLE, start high:
  - capture in into acc, and op/cnt into op_q/cnt_q;
  - go to ST8.
- IDLE, start low: stay in IDLE; acc, op_q and cnt_q hold.
- ST8, ST4, ST2, ST1 (stage k = 8, 4, 2, 1):
  - if the cnt_q bit for k is set (bit 3, 2, 1, 0 respectively), acc <= stage(acc, op_q, k);
  - otherwise acc holds;
  - advance to the next state in sequence.
- Leaving ST1:
  - out <= the final stage value; done <= 1 for one cycle;
  - go to IDLE.
- Stage semantics for amount k:
  - ROL: bits leaving the MSB end re-enter at the LSB;
  - SLL: zeros fill the LSBs;
  - SRA: in[15] of the current acc fills the MSBs;
  - SRL: zeros fill the MSBs.
- Composition of passes gives the exact cnt-bit shift for every op. SRA sign is preserved because each pass replicates the current bit 15, which never changes under SRA.
- cnt = 0: all four passes bypass; out = captured in after the normal latency. No early exit.
- start while busy: ignored. No queueing, no error flag; in, op and cnt are not re-sampled.
- Inputs changing while busy: no effect on the result.
- out changes only on the ST1 exit edge and on reset; it is stable throughout busy.

## Timing
- Reset (asynchronous assert, any state): state = IDLE, busy = 0, done = 0, out = 16'h0000; acc, op_q and cnt_q cleared. An in-flight request is discarded with no done pulse.
- Reset deassertion: first request can be accepted on the next rising edge.
- Latency:
  - start accepted at edge E0;
  - busy high in cycles E0–E4;
  - out updated and done high in the cycle after E4, i.e. 4 cycles after acceptance.
- done and busy = 0 appear in the same cycle. A start in that cycle is accepted (back-to-back), so the sustained rate is one request per 5 cycles.
- done never asserts for two consecutive cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package shift_pkg holds:
  - op encodings OP_ROL = 2'b00, OP_SLL = 2'b01, OP_SRA = 2'b10, OP_SRL = 2'b11;
  - state encoding for the five states.
- Sub-module shift_stage: purely combinational, with ports in[15:0], op[1:0], amt[1:0] (00 = 1, 01 = 2, 10 = 4, 11 = 8) and out[15:0]. It is instantiated once; the controller drives amt from state and bypasses the stage when the cnt_q bit is clear.
- Controller holds the FSM, acc, op_q, cnt_q, out and done registers.

## Test plan
- Reset, then in = 16'h8001, op = ROL, cnt = 4 → done 4 cycles after acceptance with out = 16'h0018; busy high exactly 4 cycles.
- in = 16'h00FF, op = SLL, cnt = 8 → out = 16'hFF00. Then in = 16'h8000, op = SRA, cnt = 15 → out = 16'hFFFF.
- in = 16'h8000, op = SRL, cnt = 15 → out = 16'h0001. Then cnt = 0 with in = 16'h1234 → out = 16'h1234 after the full 4-cycle latency.
- Request A (16'h0001, SLL, 1) accepted; start held high with B = (16'hFFFF, SRL, 4) during busy → only A completes, out = 16'h0002. B is accepted in the done cycle of A → out = 16'h0FFF 4 cycles later.
- Assert rst_n low during ST2 of a request → busy, done and out go to 0 immediately. No done pulse afterward; the next request completes normally.
- Random sweep of all op values × cnt 0–15 × random in, checked against a reference model; done pulse width is always 1 cycle.
